// File: rtl/mem_stage_if.sv
// Data-memory port bundle for the MEM stage.
// The master (mem_stage) issues a registered request with address, write
// enable and store data. The slave (the memory) answers with mem_ack_i and,
// in that same cycle, read data on mem_rdata_i.
//   mem_req_o    master->slave  access request, held until acked or aborted
//   mem_we_o     master->slave  1 = write
//   mem_addr_o   master->slave  word address (byte address [31:2])
//   mem_wdata_o  master->slave  store data
//   mem_ack_i    slave->master  access complete
//   mem_rdata_i  slave->master  read data, valid with mem_ack_i
interface mem_stage_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Runs loads/stores against the data-memory port (req/ack handshake), stalls
// the front of the pipeline while an access is outstanding, registers the
// MEM/WB pipeline fields and resolves the branch decision.
//   clk, reset_n            clock, asynchronous active-low reset
//   BranchIN..zeroIN        EX/MEM control bits
//   ALU_IN                  ALU result / byte address
//   readData2IN             store data
//   DestinoIN               destination register
//   PCSrcOUT                BranchIN & zeroIN (combinational)
//   stall_o                 freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//   mem                     data-memory port (master side)
//   err_o                   sticky: misaligned access or access timeout
//   RegWriteOUT..DestinoOUT MEM/WB pipeline register
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        BranchIN,
  input  logic        MemReadIN,
  input  logic        MemtoRegIN,
  input  logic        MemWriteIN,
  input  logic        RegWriteIN,
  input  logic        zeroIN,
  input  logic [31:0] ALU_IN,
  input  logic [31:0] readData2IN,
  input  logic [4:0]  DestinoIN,
  output logic        PCSrcOUT,
  output logic        stall_o,
  mem_stage_if.master mem,
  output logic        err_o,
  output logic        RegWriteOUT,
  output logic        MemtoRegOUT,
  output logic [31:0] readDataOUT,
  output logic [31:0] ALU_OUT,
  output logic [4:0]  DestinoOUT
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [29:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          rw_q, rw_d;
  logic          m2r_q, m2r_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   alu_q, alu_d;
  logic [4:0]    dst_q, dst_d;

  logic access, misaligned, is_busy, start, acked, timeout, stall;

  always_comb begin
    access     = MemReadIN | MemWriteIN;
    misaligned = access & (ALU_IN[1:0] != 2'b00);
    is_busy    = (state_q == BUSY);
    start      = ~is_busy & access & ~misaligned;
    acked      = is_busy & mem.mem_ack_i;
    // Ack on the last allowed cycle wins over the timeout.
    timeout    = is_busy & ~mem.mem_ack_i & (cnt_q == CNT_LAST);
    stall      = start | (is_busy & ~mem.mem_ack_i & ~timeout);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    dst_d   = dst_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = MemWriteIN;
          addr_d  = ALU_IN[31:2];
          wdata_d = readData2IN;
        end
        if (misaligned) err_d = 1'b1;
      end
      BUSY: begin
        if (acked) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (timeout) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // MEM/WB: bubble while stalled, otherwise capture the instruction. A
    // misaligned or timed-out access completes without a register write.
    if (stall) begin
      rw_d  = 1'b0;
      m2r_d = 1'b0;
    end else begin
      rw_d  = RegWriteIN & ~(~is_busy & misaligned) & ~timeout;
      m2r_d = MemtoRegIN;
      alu_d = ALU_IN;
      dst_d = DestinoIN;
    end
    if (acked & ~we_q) rdata_d = mem.mem_rdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      dst_q   <= dst_d;
    end
  end

  assign PCSrcOUT        = BranchIN & zeroIN;
  assign stall_o         = stall;
  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign err_o           = err_q;
  assign RegWriteOUT     = rw_q;
  assign MemtoRegOUT     = m2r_q;
  assign readDataOUT     = rdata_q;
  assign ALU_OUT         = alu_q;
  assign DestinoOUT      = dst_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage with TIMEOUT = 4. A memory responder acks k cycles
// after the request rises; a transaction-level model predicts stall length,
// request length and the MEM/WB contents after each instruction.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        BranchIN = 0, MemReadIN = 0, MemtoRegIN = 0, MemWriteIN = 0;
  logic        RegWriteIN = 0, zeroIN = 0;
  logic [31:0] ALU_IN = '0, readData2IN = '0;
  logic [4:0]  DestinoIN = '0;
  logic        PCSrcOUT, stall_o, err_o, RegWriteOUT, MemtoRegOUT;
  logic [31:0] readDataOUT, ALU_OUT;
  logic [4:0]  DestinoOUT;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .BranchIN(BranchIN), .MemReadIN(MemReadIN), .MemtoRegIN(MemtoRegIN),
    .MemWriteIN(MemWriteIN), .RegWriteIN(RegWriteIN), .zeroIN(zeroIN),
    .ALU_IN(ALU_IN), .readData2IN(readData2IN), .DestinoIN(DestinoIN),
    .PCSrcOUT(PCSrcOUT), .stall_o(stall_o), .mem(bus.master),
    .err_o(err_o), .RegWriteOUT(RegWriteOUT), .MemtoRegOUT(MemtoRegOUT),
    .readDataOUT(readDataOUT), .ALU_OUT(ALU_OUT), .DestinoOUT(DestinoOUT)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what MEM/WB and err_o should hold.
  logic        m_rw, m_m2r, m_err;
  logic [31:0] m_alu, m_rdata;
  logic [4:0]  m_dst;

  task automatic model_reset();
    m_rw = 0; m_m2r = 0; m_err = 0; m_alu = '0; m_rdata = '0; m_dst = '0;
  endtask

  // Transaction-level rules: an aligned access acked k cycles after the
  // request completes after k+1 stall cycles; no ack within TO cycles aborts.
  task automatic model_step(input logic rd, wr, m2r, rw, input logic [31:0] alu,
                            input logic [4:0] dst, input int k, input logic [31:0] rdat,
                            output int exp_stall, output int exp_req);
    bit acc, mis, tmo;
    acc = rd | wr;
    mis = acc && (alu % 4 != 0);
    tmo = acc && !mis && (k >= TO);
    exp_stall = (acc && !mis) ? (tmo ? TO : k + 1) : 0;
    exp_req   = exp_stall;
    if (mis || tmo) m_err = 1;
    m_rw  = rw && !mis && !tmo;
    m_m2r = m2r;
    m_alu = alu;
    m_dst = dst;
    if (rd && !wr && acc && !mis && !tmo) m_rdata = rdat;
  endtask

  // Present one instruction (entered at posedge+1), act as the memory, and
  // report observations. Ends at posedge+1 of the completing edge.
  task automatic drive_instr(input logic br, rd, m2r, wr, rw, zr,
                             input logic [31:0] alu, sd, input logic [4:0] dst,
                             input int k, input logic [31:0] rdat, input bit noise,
                             output int stall_n, output int req_n, output int bad_bub,
                             output int bad_bus, output logic pcs, output bit hung);
    int  busy;
    bit  done;
    BranchIN = br; MemReadIN = rd; MemtoRegIN = m2r; MemWriteIN = wr;
    RegWriteIN = rw; zeroIN = zr; ALU_IN = alu; readData2IN = sd; DestinoIN = dst;
    bus.mem_ack_i = 0;
    stall_n = 0; req_n = 0; bad_bub = 0; bad_bus = 0; busy = 0; done = 0; pcs = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (bus.mem_req_o === 1'b1) begin
        req_n++;
        if (bus.mem_addr_o !== alu[31:2] || bus.mem_we_o !== wr || bus.mem_wdata_o !== sd)
          bad_bus++;
        if (busy == k) begin
          bus.mem_ack_i = 1; bus.mem_rdata_i = rdat;
        end
        busy++;
      end else if (noise) begin
        bus.mem_ack_i = 1; bus.mem_rdata_i = $urandom;
      end
      #1;
      if (cyc == 0) pcs = PCSrcOUT;
      if (stall_o === 1'b1) stall_n++;
      else done = 1;
      @(posedge clk); #1;
      bus.mem_ack_i = 0;
      if (!done && (RegWriteOUT !== 1'b0 || MemtoRegOUT !== 1'b0 || ALU_OUT !== m_alu ||
                    DestinoOUT !== m_dst || readDataOUT !== m_rdata))
        bad_bub++;
    end
    hung = !done;
  endtask

  task automatic test_reset();
    reset_n = 0;
    bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
    #12;
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, err_o, RegWriteOUT, MemtoRegOUT} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.mem_req_o, bus.mem_we_o, err_o, RegWriteOUT, MemtoRegOUT});
    end
    n_checks++;
    if ({bus.mem_addr_o, bus.mem_wdata_o, readDataOUT, ALU_OUT, DestinoOUT} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h alu %h dst %h expected all 0",
               bus.mem_addr_o, bus.mem_wdata_o, readDataOUT, ALU_OUT, DestinoOUT);
    end
    model_reset();
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    int s, r, bb, bs, es, er; logic p; bit h;
    drive_instr(0, 0, 0, 0, 1, 0, 32'h10, 32'h0, 5'd5, 0, 0, 0, s, r, bb, bs, p, h);
    model_step(0, 0, 0, 1, 32'h10, 5'd5, 0, 0, es, er);
    n_checks++;
    if (s !== 0) begin n_fail++; $display("FAIL alu_stall: got %0d expected 0", s); end
    n_checks++;
    if ({ALU_OUT, DestinoOUT, RegWriteOUT} !== {32'h10, 5'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL alu_wb: got alu %h dst %0d rw %b expected 10 5 1", ALU_OUT, DestinoOUT, RegWriteOUT);
    end
  endtask

  task automatic test_load();
    int s, r, bb, bs, es, er; logic p; bit h;
    drive_instr(0, 1, 1, 0, 1, 0, 32'h100, 32'h0, 5'd9, 2, 32'hCAFEF00D, 0, s, r, bb, bs, p, h);
    model_step(1, 0, 1, 1, 32'h100, 5'd9, 2, 32'hCAFEF00D, es, er);
    n_checks++;
    if (s !== 3 || r !== 3) begin
      n_fail++; $display("FAIL load_len: got stall %0d req %0d expected 3 3", s, r);
    end
    n_checks++;
    if (bb !== 0 || bs !== 0 || h) begin
      n_fail++; $display("FAIL load_bubble_bus: got %0d bad bubbles %0d bad bus hung %0d expected 0 0 0", bb, bs, h);
    end
    n_checks++;
    if (bus.mem_addr_o !== 30'h40) begin
      n_fail++; $display("FAIL load_addr: got %h expected 40", bus.mem_addr_o);
    end
    n_checks++;
    if ({readDataOUT, RegWriteOUT, MemtoRegOUT, bus.mem_req_o} !== {32'hCAFEF00D, 3'b110}) begin
      n_fail++;
      $display("FAIL load_wb: got rdata %h rw %b m2r %b req %b expected cafef00d 1 1 0",
               readDataOUT, RegWriteOUT, MemtoRegOUT, bus.mem_req_o);
    end
  endtask

  task automatic test_store();
    int s, r, bb, bs, es, er; logic p; bit h;
    drive_instr(0, 0, 0, 1, 0, 0, 32'h8, 32'h12345678, 5'd0, 0, 32'hDEADBEEF, 0, s, r, bb, bs, p, h);
    model_step(0, 1, 0, 0, 32'h8, 5'd0, 0, 32'hDEADBEEF, es, er);
    n_checks++;
    if (s !== 1 || r !== 1 || bb !== 0 || bs !== 0) begin
      n_fail++; $display("FAIL store_len: got stall %0d req %0d bub %0d bus %0d expected 1 1 0 0", s, r, bb, bs);
    end
    n_checks++;
    if ({bus.mem_we_o, bus.mem_wdata_o, readDataOUT, RegWriteOUT} !== {1'b1, 32'h12345678, m_rdata, 1'b0}) begin
      n_fail++;
      $display("FAIL store_wb: got we %b wdata %h rdata %h rw %b expected 1 12345678 %h 0",
               bus.mem_we_o, bus.mem_wdata_o, readDataOUT, RegWriteOUT, m_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int s, r, bb, bs, es, er; logic p; bit h;
    drive_instr(0, 1, 1, 0, 1, 0, 32'h20, 32'h0, 5'd3, 0, 32'h11112222, 0, s, r, bb, bs, p, h);
    model_step(1, 0, 1, 1, 32'h20, 5'd3, 0, 32'h11112222, es, er);
    n_checks++;
    if (s !== es || r !== er || readDataOUT !== m_rdata) begin
      n_fail++; $display("FAIL b2b_first: got stall %0d req %0d rdata %h expected %0d %0d %h", s, r, readDataOUT, es, er, m_rdata);
    end
    // Ack on the last cycle before the timeout must still complete the load.
    drive_instr(0, 1, 1, 0, 1, 0, 32'h24, 32'h0, 5'd4, TO - 1, 32'h33334444, 0, s, r, bb, bs, p, h);
    model_step(1, 0, 1, 1, 32'h24, 5'd4, TO - 1, 32'h33334444, es, er);
    n_checks++;
    if (s !== es || r !== er || bb !== 0 || bs !== 0) begin
      n_fail++; $display("FAIL b2b_second_len: got stall %0d req %0d bub %0d bus %0d expected %0d %0d 0 0", s, r, bb, bs, es, er);
    end
    n_checks++;
    if ({readDataOUT, RegWriteOUT, err_o} !== {m_rdata, m_rw, m_err}) begin
      n_fail++; $display("FAIL b2b_second_wb: got rdata %h rw %b err %b expected %h %b %b", readDataOUT, RegWriteOUT, err_o, m_rdata, m_rw, m_err);
    end
  endtask

  task automatic test_misaligned();
    int s, r, bb, bs, es, er; logic p; bit h;
    drive_instr(0, 1, 1, 0, 1, 0, 32'h102, 32'h0, 5'd7, 0, 32'h55555555, 0, s, r, bb, bs, p, h);
    model_step(1, 0, 1, 1, 32'h102, 5'd7, 0, 32'h55555555, es, er);
    n_checks++;
    if (s !== 0 || r !== 0) begin
      n_fail++; $display("FAIL misaligned_len: got stall %0d req %0d expected 0 0", s, r);
    end
    n_checks++;
    if ({err_o, RegWriteOUT, ALU_OUT} !== {2'b10, 32'h102}) begin
      n_fail++; $display("FAIL misaligned_wb: got err %b rw %b alu %h expected 1 0 102", err_o, RegWriteOUT, ALU_OUT);
    end
  endtask

  task automatic test_timeout();
    int s, r, bb, bs, es, er; logic p; bit h;
    drive_instr(0, 1, 1, 0, 1, 0, 32'h300, 32'h0, 5'd8, 1000, 32'h0, 0, s, r, bb, bs, p, h);
    model_step(1, 0, 1, 1, 32'h300, 5'd8, 1000, 32'h0, es, er);
    n_checks++;
    if (s !== TO || r !== TO || h) begin
      n_fail++; $display("FAIL timeout_len: got stall %0d req %0d hung %0d expected %0d %0d 0", s, r, h, TO, TO);
    end
    n_checks++;
    if ({err_o, RegWriteOUT, bus.mem_req_o, readDataOUT} !== {3'b100, m_rdata}) begin
      n_fail++; $display("FAIL timeout_wb: got err %b rw %b req %b rdata %h expected 1 0 0 %h",
                         err_o, RegWriteOUT, bus.mem_req_o, readDataOUT, m_rdata);
    end
    drive_instr(0, 0, 0, 0, 1, 0, 32'hABC, 32'h0, 5'd1, 0, 0, 0, s, r, bb, bs, p, h);
    model_step(0, 0, 0, 1, 32'hABC, 5'd1, 0, 0, es, er);
    n_checks++;
    if (s !== 0 || RegWriteOUT !== 1'b1 || ALU_OUT !== 32'hABC) begin
      n_fail++; $display("FAIL timeout_resume: got stall %0d rw %b alu %h expected 0 1 abc", s, RegWriteOUT, ALU_OUT);
    end
  endtask

  task automatic test_reset_mid();
    int s, r, bb, bs, es, er; logic p; bit h;
    MemReadIN = 1; MemtoRegIN = 1; RegWriteIN = 1; MemWriteIN = 0; BranchIN = 0;
    ALU_IN = 32'h200; DestinoIN = 5'd2; bus.mem_ack_i = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL resetmid_req: got %b expected 1", bus.mem_req_o);
    end
    #2 reset_n = 0;
    #1;
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, err_o, RegWriteOUT, MemtoRegOUT,
         readDataOUT, ALU_OUT, DestinoOUT} !== '0) begin
      n_fail++; $display("FAIL resetmid_async: got req %b addr %h err %b rw %b alu %h expected all 0",
                         bus.mem_req_o, bus.mem_addr_o, err_o, RegWriteOUT, ALU_OUT);
    end
    MemReadIN = 0; MemtoRegIN = 0; RegWriteIN = 0; ALU_IN = '0; DestinoIN = '0;
    model_reset();
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hBADBAD00;
    @(negedge clk);
    n_checks++;
    if (bus.mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL resetmid_late_ack: got req %b stall %b expected 0 0", bus.mem_req_o, stall_o);
    end
    @(posedge clk); #1;
    bus.mem_ack_i = 0;
    drive_instr(0, 0, 0, 0, 1, 0, 32'h44, 32'h0, 5'd6, 0, 0, 0, s, r, bb, bs, p, h);
    model_step(0, 0, 0, 1, 32'h44, 5'd6, 0, 0, es, er);
    n_checks++;
    if (s !== 0 || {RegWriteOUT, ALU_OUT, readDataOUT, err_o} !== {1'b1, 32'h44, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL resetmid_after: got stall %0d rw %b alu %h rdata %h err %b expected 0 1 44 0 0",
                         s, RegWriteOUT, ALU_OUT, readDataOUT, err_o);
    end
  endtask

  task automatic test_random();
    int s, r, bb, bs, es, er, op, k; logic p; bit h;
    logic br, rd, wr, m2r, rw, zr; logic [31:0] alu, sd, rdat; logic [4:0] dst;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      br = 0; rd = 0; wr = 0; zr = 1'($urandom);
      rw = 1'($urandom); m2r = 1'($urandom);
      alu = $urandom & 32'hFFFF_FFFC; sd = $urandom; dst = 5'($urandom);
      rdat = $urandom; k = $urandom_range(0, TO + 1);
      case (op)
        3:       begin br = 1; rw = 0; end
        4, 5, 6: rd = 1;
        7, 8:    begin wr = 1; rd = ($urandom_range(0, 3) == 0); end
        9:       begin rd = 1'($urandom); wr = ~rd; alu = alu | 32'($urandom_range(1, 3)); end
        default: ;
      endcase
      drive_instr(br, rd, m2r, wr, rw, zr, alu, sd, dst, k, rdat, 1'($urandom), s, r, bb, bs, p, h);
      model_step(rd, wr, m2r, rw, alu, dst, k, rdat, es, er);
      n_checks++;
      if (s !== es || r !== er || h) begin
        n_fail++; $display("FAIL rand_len[%0d]: got stall %0d req %0d hung %0d expected %0d %0d 0", i, s, r, h, es, er);
      end
      n_checks++;
      if (bb !== 0 || bs !== 0) begin
        n_fail++; $display("FAIL rand_bubble_bus[%0d]: got bub %0d bus %0d expected 0 0", i, bb, bs);
      end
      n_checks++;
      if (p !== (br & zr)) begin
        n_fail++; $display("FAIL rand_pcsrc[%0d]: got %b expected %b", i, p, br & zr);
      end
      n_checks++;
      if ({RegWriteOUT, MemtoRegOUT, ALU_OUT, DestinoOUT, readDataOUT, err_o, bus.mem_req_o} !==
          {m_rw, m_m2r, m_alu, m_dst, m_rdata, m_err, 1'b0}) begin
        n_fail++;
        $display("FAIL rand_wb[%0d]: got rw %b m2r %b alu %h dst %0d rdata %h err %b req %b expected %b %b %h %0d %h %b 0",
                 i, RegWriteOUT, MemtoRegOUT, ALU_OUT, DestinoOUT, readDataOUT, err_o, bus.mem_req_o,
                 m_rw, m_m2r, m_alu, m_dst, m_rdata, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline. It sits downstream of the EX/MEM pipeline register and consumes its outputs. It runs load/store accesses against a data-memory port with a req/ack handshake, stalls the front of the pipeline while an access is outstanding, and registers results into MEM/WB. It also resolves the branch decision (PCSrc) for the fetch stage.

## Interface
Parameters:
- TIMEOUT, 15: maximum BUSY cycles allowed without mem_ack_i before the access is aborted (≥2).

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, RegWriteIN, zeroIN  in  1 each  control bits from EX/MEM
- ALU_IN  in  32  ALU result / byte address
- readData2IN  in  32  store data
- DestinoIN  in  5  destination register
- PCSrcOUT  out  1  BranchIN & zeroIN, combinational
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- mem_req_o  out  1  access request, registered
- mem_we_o  out  1  1 = write, registered
- mem_addr_o  out  30  word address ALU_IN[31:2], registered
- mem_wdata_o  out  32  store data, registered
- mem_ack_i  in  1  access complete; read data valid same cycle
- mem_rdata_i  in  32  read data
- err_o  out  1  sticky: misaligned access or timeout
- RegWriteOUT, MemtoRegOUT  out  1 each  MEM/WB control
- readDataOUT, ALU_OUT  out  32 each  MEM/WB data
- DestinoOUT  out  5  MEM/WB destination

## Operation
- Reset (async, reset_n=0): state IDLE; timeout counter 0; every registered output 0, including err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and all MEM/WB outputs.
- FSM states: IDLE and BUSY.
- access = MemReadIN | MemWriteIN. If both bits are set, the access is a write.
- misaligned = access & (ALU_IN[1:0] != 0).
- In IDLE with access and not misaligned:
  - stall_o = 1.
  - Next edge: go to BUSY; latch mem_addr_o, mem_wdata_o, mem_we_o; set mem_req_o = 1; clear the counter.
- In IDLE with misaligned:
  - No request is issued and stall_o = 0.
  - err_o is set to 1.
  - The instruction passes to MEM/WB with RegWriteOUT forced to 0.
- In BUSY:
  - stall_o = ~mem_ack_i.
  - On ack: next edge returns to IDLE and mem_req_o = 0.
  - On no ack: the counter increments. If counter == TIMEOUT-1, the next edge sets err_o, returns to IDLE, drops mem_req_o, and completes the instruction with RegWriteOUT = 0 (stall_o = 0 in that cycle).
- mem_ack_i is ignored in IDLE.
- mem_req_o stays stable while in BUSY.
- MEM/WB update, every edge:
  - If stall_o = 1: insert a bubble (RegWriteOUT = 0, MemtoRegOUT = 0); data fields hold.
  - Otherwise capture RegWriteIN (gated as above), MemtoRegIN, ALU_IN and DestinoIN.
  - readDataOUT <= mem_rdata_i when a read is acked. Otherwise readDataOUT holds.
- err_o clears only on reset.
- PCSrcOUT is purely combinational and never gated by stall_o. Branch instructions do not access memory.

## Timing
- Non-memory instruction: MEM/WB updated 1 edge after it appears at the inputs; no stall.
- Load/store (edges are numbered from when the instruction is presented):
  - Edge e0: the instruction is presented; stall_o = 1 combinationally.
  - Edge e1: mem_req_o = 1.
  - If ack arrives k cycles after e1 (k ≥ 0), stall_o falls in that cycle. MEM/WB captures and mem_req_o falls at the following edge.
  - Total stall cycles = k + 1. Minimum stage latency = 2 cycles.
- Timeout: at most TIMEOUT BUSY cycles, so stall_o is high for TIMEOUT cycles total including the IDLE cycle.
- Reset asserted mid-access: mem_req_o drops immediately (asynchronous), the FSM returns to IDLE, and the access is abandoned. A late ack after reset is ignored.
- Back-to-back loads: the second load is presented the cycle after the first completes, enters IDLE-with-access immediately, and mem_req_o shows a 1-cycle low gap.

## Test plan
- ALU op: RegWriteIN=1, ALU_IN=32'h00000010, DestinoIN=5 → next edge: ALU_OUT=0x10, DestinoOUT=5, RegWriteOUT=1, stall_o never high.
- Load, ack after 2 cycles: MemReadIN=1, MemtoRegIN=1, ALU_IN=0x100, mem_rdata_i=0xCAFEF00D → mem_addr_o=0x40; stall_o high 3 cycles; readDataOUT=0xCAFEF00D; RegWriteOUT=1 for exactly one cycle; bubbles (RegWriteOUT=0) during the stall.
- Store, immediate ack: MemWriteIN=1, ALU_IN=0x8, readData2IN=0x12345678 → mem_we_o=1, mem_wdata_o=0x12345678, mem_req_o high 1 cycle, stall 1 cycle.
- Misaligned: MemReadIN=1, ALU_IN=0x102 → mem_req_o stays 0, err_o=1 from next edge, RegWriteOUT=0, no stall.
- Timeout, TIMEOUT=4, no ack → mem_req_o high 4 cycles then 0; err_o=1; RegWriteOUT=0; pipeline resumes.
- Reset mid-access: drop reset_n while mem_req_o=1 → all outputs 0 asynchronously; after release, a late ack is ignored and the FSM stays in IDLE.
